sum_window_acc: RTL and testbench

//  Downstream consumer of the 8-bit adder result stream (uo_out = ui_in + uio_in).

---
 rtl/sum_window_acc.sv | 94 +++++++++
 tb/tb_sum_window_acc.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sum_window_acc.sv
// Windowed accumulator for the adder result stream: sums WINDOW samples with
// saturation and presents each window total on a valid/ready output.
module sum_window_acc #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WINDOW = 4,
  parameter int unsigned ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int unsigned CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

  generate
    if (ACC_W < DATA_W) begin : g_bad_acc_w
      $error("ACC_W must be >= DATA_W");
    end
    if (WINDOW < 1 || WINDOW > 255) begin : g_bad_window
      $error("WINDOW must be in 1..255");
    end
  endgenerate

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [SUM_W-1:0] next_sum;
  logic             carry;
  logic [ACC_W-1:0] sat_sum;
  logic             accept;
  logic             take;
  logic             last;

  // Input side only stalls while a finished window waits for the consumer.
  assign in_ready = !out_valid || out_ready;

  // One-bit-wider sum exposes the carry that drives saturation.
  always_comb begin
    next_sum = {1'b0, acc} + SUM_W'(in_data);
    carry    = next_sum[ACC_W];
    sat_sum  = carry ? {ACC_W{1'b1}} : next_sum[ACC_W-1:0];
    accept   = in_valid && in_ready;
    take     = out_valid && out_ready;
    last     = (cnt == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (take) begin
        out_valid <= 1'b0;
      end
      // A completing accept in the same cycle as a take reloads the output.
      if (accept) begin
        if (last) begin
          out_sum   <= sat_sum;
          out_ovf   <= ovf | carry;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          ovf       <= 1'b0;
        end else begin
          acc <= sat_sum;
          ovf <= ovf | carry;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sum_window_acc.sv
// Directed bench for sum_window_acc: three instances (default, 9-bit
// saturating, single-sample window) share stimulus; each test checks one.
module tb_sum_window_acc;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic        m_in_ready, m_valid, m_ovf;
  logic [15:0] m_sum;
  logic        s_in_ready, s_valid, s_ovf;
  logic [8:0]  s_sum;
  logic        w_in_ready, w_valid, w_ovf;
  logic [15:0] w_sum;

  int vectors;
  int miscompares;

  sum_window_acc #(.DATA_W(8), .WINDOW(4), .ACC_W(16)) u_main (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .in_ready(m_in_ready), .out_valid(m_valid),
    .out_ready(out_ready), .out_sum(m_sum), .out_ovf(m_ovf)
  );

  sum_window_acc #(.DATA_W(8), .WINDOW(4), .ACC_W(9)) u_sat (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .in_ready(s_in_ready), .out_valid(s_valid),
    .out_ready(out_ready), .out_sum(s_sum), .out_ovf(s_ovf)
  );

  sum_window_acc #(.DATA_W(8), .WINDOW(1), .ACC_W(16)) u_w1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .in_ready(w_in_ready), .out_valid(w_valid),
    .out_ready(out_ready), .out_sum(w_sum), .out_ovf(w_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: sim time expired before summary");
    $fatal(1);
  end

  // Leaves the bench at posedge+1 with reset released and inputs idle.
  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #3;
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    vectors++; if (m_sum !== 16'd0) begin miscompares++; $display("FAIL reset_sum: got %0d want 0", m_sum); end
    vectors++; if (m_ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", m_ovf); end
    vectors++; if (m_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", m_in_ready); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic_window();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(10 * (i + 1));
      @(posedge clk); #1;
      if (i < 3) begin
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL t1_early_valid[%0d]: got %b want 0", i, m_valid); end
      end
    end
    in_valid = 1'b0;
    vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL t1_valid: got %b want 1", m_valid); end
    vectors++; if (m_sum !== 16'd100) begin miscompares++; $display("FAIL t1_sum: got %0d want 100", m_sum); end
    vectors++; if (m_ovf !== 1'b0) begin miscompares++; $display("FAIL t1_ovf: got %b want 0", m_ovf); end
    @(posedge clk); #1;
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL t1_taken: got %b want 0", m_valid); end
    vectors++; if (m_sum !== 16'd100) begin miscompares++; $display("FAIL t1_sum_hold: got %0d want 100", m_sum); end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'd255;
      @(posedge clk); #1;
    end
    vectors++; if (s_valid !== 1'b1) begin miscompares++; $display("FAIL t2_valid: got %b want 1", s_valid); end
    vectors++; if (s_sum !== 9'd511) begin miscompares++; $display("FAIL t2_sat_sum: got %0d want 511", s_sum); end
    vectors++; if (s_ovf !== 1'b1) begin miscompares++; $display("FAIL t2_sat_ovf: got %b want 1", s_ovf); end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'd1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    vectors++; if (s_valid !== 1'b1) begin miscompares++; $display("FAIL t2_next_valid: got %b want 1", s_valid); end
    vectors++; if (s_sum !== 9'd4) begin miscompares++; $display("FAIL t2_next_sum: got %0d want 4", s_sum); end
    vectors++; if (s_ovf !== 1'b0) begin miscompares++; $display("FAIL t2_next_ovf: got %b want 0", s_ovf); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(10 * (i + 1));
      @(posedge clk); #1;
    end
    // Next sample is held pending while the finished window is stalled.
    in_valid = 1'b1; in_data = 8'd5;
    #1;
    vectors++; if (m_in_ready !== 1'b0) begin miscompares++; $display("FAIL t3_in_ready: got %b want 0", m_in_ready); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      vectors++; if (m_valid !== 1'b1 || m_sum !== 16'd100) begin miscompares++; $display("FAIL t3_stall[%0d]: got valid=%b sum=%0d want valid=1 sum=100", i, m_valid, m_sum); end
      vectors++; if (w_sum !== 16'd10) begin miscompares++; $display("FAIL t3_w1_stall[%0d]: got %0d want 10", i, w_sum); end
    end
    out_ready = 1'b1;
    #1;
    vectors++; if (m_in_ready !== 1'b1) begin miscompares++; $display("FAIL t3_release_ready: got %b want 1", m_in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL t3_taken: got %b want 0", m_valid); end
    vectors++; if (w_valid !== 1'b1 || w_sum !== 16'd5) begin miscompares++; $display("FAIL t3_w1_overlap: got valid=%b sum=%0d want valid=1 sum=5", w_valid, w_sum); end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(6 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    vectors++; if (m_valid !== 1'b1 || m_sum !== 16'd26) begin miscompares++; $display("FAIL t3_resume: got valid=%b sum=%0d want valid=1 sum=26", m_valid, m_sum); end
  endtask

  task automatic test_window_one();
    do_reset();
    out_ready = 1'b1;
    vectors++; if (w_valid !== 1'b0) begin miscompares++; $display("FAIL t4_idle: got %b want 0", w_valid); end
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      @(posedge clk); #1;
      vectors++; if (w_valid !== 1'b1 || w_sum !== 16'(i)) begin miscompares++; $display("FAIL t4_stream[%0d]: got valid=%b sum=%0d want valid=1 sum=%0d", i, w_valid, w_sum, i); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (w_valid !== 1'b0) begin miscompares++; $display("FAIL t4_drain: got %b want 0", w_valid); end
  endtask

  task automatic test_clear();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'(5 + i);
      @(posedge clk); #1;
    end
    clear = 1'b1; in_valid = 1'b1; in_data = 8'd99;
    @(posedge clk); #1;
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    vectors++; if (m_valid !== 1'b1 || m_sum !== 16'd10) begin miscompares++; $display("FAIL t5_after_clear: got valid=%b sum=%0d want valid=1 sum=10", m_valid, m_sum); end
    out_ready = 1'b0; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL t5_clear_valid: got %b want 0", m_valid); end
    vectors++; if (m_sum !== 16'd0) begin miscompares++; $display("FAIL t5_clear_sum: got %0d want 0", m_sum); end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(10 * (i + 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL t6_pending: got %b want 1", m_valid); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (m_valid !== 1'b0 || m_sum !== 16'd0 || m_ovf !== 1'b0) begin miscompares++; $display("FAIL t6_async_out: got valid=%b sum=%0d ovf=%b want 0 0 0", m_valid, m_sum, m_ovf); end
    vectors++; if (m_in_ready !== 1'b1) begin miscompares++; $display("FAIL t6_in_ready: got %b want 1", m_in_ready); end
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'd7;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL t6_quiet[%0d]: got %b want 0", i, m_valid); end
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'd7;
      @(posedge clk); #1;
      if (i == 1) begin
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL t6_partial_lost: got %b want 0", m_valid); end
      end
    end
    in_valid = 1'b0;
    vectors++; if (m_valid !== 1'b1 || m_sum !== 16'd28) begin miscompares++; $display("FAIL t6_after_reset: got valid=%b sum=%0d want valid=1 sum=28", m_valid, m_sum); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic_window();
    test_saturation();
    test_backpressure();
    test_window_one();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
